// File: rtl/mux_pkg.sv
// Shared select-width constants and select type for the 8:1 lane selector.
package mux_pkg;

  localparam int SEL_W = 3;
  localparam int N_IN  = 8;

  typedef logic [SEL_W-1:0] sel_t;

endpackage : mux_pkg

// File: rtl/mux_sel_decode.sv
// 3-to-8 one-hot select decoder, purely combinational, no flow control.
// An X/Z select bit makes the equality compares X, so X reaches the data path.
module mux_sel_decode
  import mux_pkg::*;
(
  input  sel_t            sel_i,
  output logic [N_IN-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N_IN; i++) begin
      onehot_o[i] = (sel_i == SEL_W'(i));
    end
  end

endmodule : mux_sel_decode

// File: rtl/mux.sv
// 8:1 lane selector: one-hot AND-OR data path, output registered (1 cycle, async reset)
// or combinational (0 cycles) per OUT_REG; loads every cycle, no backpressure.
module mux
  import mux_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int OUT_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [WIDTH-1:0] a4,
  input  logic [WIDTH-1:0] a5,
  input  logic [WIDTH-1:0] a6,
  input  logic [WIDTH-1:0] a7,
  input  logic             s0,
  input  logic             s1,
  input  logic             s2,
  output logic [WIDTH-1:0] y
);

  sel_t             sel;
  logic [N_IN-1:0]  onehot;
  logic [WIDTH-1:0] lane [N_IN];
  logic [WIDTH-1:0] y_d;

  assign sel = {s2, s1, s0};

  mux_sel_decode u_sel_decode (
    .sel_i    (sel),
    .onehot_o (onehot)
  );

  assign lane[0] = a0;
  assign lane[1] = a1;
  assign lane[2] = a2;
  assign lane[3] = a3;
  assign lane[4] = a4;
  assign lane[5] = a5;
  assign lane[6] = a6;
  assign lane[7] = a7;

  // Per output bit: mask each lane's bit with its select line, then OR-reduce.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [N_IN-1:0] col;
    for (genvar i = 0; i < N_IN; i++) begin : g_lane
      assign col[i] = lane[i][b] & onehot[i];
    end
    assign y_d[b] = |col;
  end

  if (OUT_REG != 0) begin : g_reg
    logic [WIDTH-1:0] y_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        y_q <= '0;
      end else begin
        y_q <= y_d;
      end
    end
    assign y = y_q;
  end else begin : g_comb
    assign y = y_d;
  end

endmodule : mux

// File: tb/tb_mux.sv
// Scoreboard bench for mux: registered WIDTH=1 instance plus combinational WIDTH=4 instance.
module tb_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] av;
  logic [2:0] sv;
  logic       y;

  logic [3:0] ca [8];
  logic [2:0] cs;
  logic [3:0] cy;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q [$];

  always #5 clk = ~clk;

  mux #(.WIDTH(1), .OUT_REG(1)) u_reg (
    .clk (clk), .rst (rst),
    .a0 (av[0]), .a1 (av[1]), .a2 (av[2]), .a3 (av[3]),
    .a4 (av[4]), .a5 (av[5]), .a6 (av[6]), .a7 (av[7]),
    .s0 (sv[0]), .s1 (sv[1]), .s2 (sv[2]),
    .y  (y)
  );

  mux #(.WIDTH(4), .OUT_REG(0)) u_comb (
    .clk (clk), .rst (rst),
    .a0 (ca[0]), .a1 (ca[1]), .a2 (ca[2]), .a3 (ca[3]),
    .a4 (ca[4]), .a5 (ca[5]), .a6 (ca[6]), .a7 (ca[7]),
    .s0 (cs[0]), .s1 (cs[1]), .s2 (cs[2]),
    .y  (cy)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [3:0] obs);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the next rising edge.
  task automatic apply_reg(input string tag, input logic [7:0] a, input logic [2:0] s,
                           input logic ex);
    @(negedge clk);
    av = a;
    sv = s;
    exp_q.push_back({3'b0, ex});
    @(posedge clk);
    #1;
    pop_check(tag, {3'b0, y});
  endtask

  typedef struct {
    logic [7:0] a;
    logic [2:0] s;
    logic       ex;
  } vec_t;

  vec_t vecs [8] = '{
    '{8'b11001101, 3'd0, 1'b1},
    '{8'b10110101, 3'd1, 1'b0},
    '{8'b11101110, 3'd2, 1'b1},
    '{8'b10001000, 3'd3, 1'b1},
    '{8'b11101011, 3'd4, 1'b0},
    '{8'b11101001, 3'd5, 1'b1},
    '{8'b10011010, 3'd6, 1'b0},
    '{8'b10001101, 3'd7, 1'b1}
  };

  initial begin
    rst = 1'b1;
    av  = 8'h01;
    sv  = 3'd0;
    cs  = 3'd0;
    for (int i = 0; i < 8; i++) ca[i] = 4'h0;

    #2;
    check("rst_between_edges", {3'b0, y}, 4'h0);
    @(posedge clk); #1;
    check("rst_after_edge1", {3'b0, y}, 4'h0);
    @(posedge clk); #1;
    check("rst_after_edge2", {3'b0, y}, 4'h0);

    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(4'h1);
    @(posedge clk); #1;
    pop_check("rst_release", {3'b0, y});

    for (int i = 0; i < 8; i++) begin
      apply_reg($sformatf("sel%0d", i), vecs[i].a, vecs[i].s, vecs[i].ex);
    end

    // Only a5 stays 1; every other lane flips each cycle.
    for (int k = 0; k < 6; k++) begin
      apply_reg($sformatf("isolate%0d", k), (k % 2 == 0) ? 8'hFF : 8'h20, 3'd5, 1'b1);
    end

    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_mid_cycle", {3'b0, y}, 4'h0);
    @(posedge clk); #1;
    check("arst_hold", {3'b0, y}, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    av  = 8'h20;
    sv  = 3'd5;
    exp_q.push_back(4'h1);
    @(posedge clk); #1;
    pop_check("arst_reload", {3'b0, y});

    apply_reg("post_reset_sel6", 8'b0100_0000, 3'd6, 1'b1);

    // Combinational instance: settle with #1, no clock edge needed.
    @(negedge clk);
    #1;
    ca[3] = 4'hA;
    cs    = 3'd3;
    exp_q.push_back(4'hA);
    #1;
    pop_check("comb_sel3", cy);
    ca[0] = 4'h5;
    cs    = 3'd0;
    exp_q.push_back(4'h5);
    #1;
    pop_check("comb_sel0", cy);
    ca[7] = 4'hC;
    cs    = 3'd7;
    exp_q.push_back(4'hC);
    #1;
    pop_check("comb_sel7", cy);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mux

// File: doc/mux.md
# mux

Eight-input, one-output selector with a registered output, used wherever a single data lane must be picked from eight sources by a 3-bit select. Select is given as three discrete bits (s2 MSB … s0 LSB). The block sits at the point where the chosen lane is handed to downstream synchronous logic, so its output is clocked and resettable.

## Interface
Parameters:
- WIDTH, 1, bit width of each data input and of y.
- OUT_REG, 1, 1 = y registered (one-cycle latency); 0 = y purely combinational. Reset has no effect in this mode.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset. One clock; reset is asynchronous and active-high.
- a0 … a7  input  WIDTH each  data inputs, index 0–7.
- s0  input  1  select bit 0 (LSB).
- s1  input  1  select bit 1.
- s2  input  1  select bit 2 (MSB).
- y  output  WIDTH  selected data.

## Operation
- Select index sel = {s2, s1, s0}, unsigned, range 0–7. Every code is valid; no illegal or default case.
- Selected value is a[sel]:
  - sel=0 → a0, 1 → a1, 2 → a2, 3 → a3
  - sel=4 → a4, 5 → a5, 6 → a6, 7 → a7
- Selection is built as a one-hot decode of sel, AND-ed per lane with the inputs and OR-reduced.
- The selection is bitwise across WIDTH. No arithmetic and no width conversion.
- Unselected inputs have no influence on y. Toggling them must not change y.
- X/Z on any select bit propagates to y in simulation. No masking.

## Timing
- OUT_REG=1:
  - y is loaded with a[sel] on every rising clk.
  - Latency is one cycle from input/select change to y change.
  - No enable and no handshake. The register loads every cycle.
- Reset (OUT_REG=1):
  - rst high forces y = 0 immediately, without waiting for clk.
  - y holds 0 while rst is high, regardless of clk or inputs.
  - On the first rising clk after rst deasserts, y loads a[sel].
  - Reset asserted mid-stream discards the pending value. No recovery of the prior y.
- Simultaneous events: if select and data change in the same cycle, the next edge captures the new data at the new select.
- OUT_REG=0:
  - y = a[sel] combinationally, zero cycles.
  - clk and rst are unused.

## Structure
- Shared package `mux_pkg`:
  - SEL_W = 3
  - N_IN = 8
  - typedef sel_t (logic [SEL_W-1:0])
- Sub-module `mux_sel_decode`: 3-to-8 one-hot decoder, sel_t → logic [N_IN-1:0]. Purely combinational.
- Top level contains:
  - select concatenation
  - decoder instance
  - AND-OR data path, generate over WIDTH
  - output register, or bypass under OUT_REG

## Test plan
WIDTH=1, OUT_REG=1. Each row is checked one clock after the inputs are applied.
- Reset: hold rst=1 with a0=1, sel=0 → y=0, including between clock edges. Release rst → y=1 after the next rising edge.
- Low codes, a7..a0 as listed:
  - a7..a0=11001101, sel=0 → y=1
  - a7..a0=10110101, sel=1 → y=0
  - a7..a0=11101110, sel=2 → y=1
  - a7..a0=10001000, sel=3 → y=1
- High codes, a7..a0 as listed:
  - a7..a0=11101011, sel=4 → y=0
  - a7..a0=11101001, sel=5 → y=1
  - a7..a0=10011010, sel=6 → y=0
  - a7..a0=10001101, sel=7 → y=1
- Isolation: sel=5 held, a5=1, toggle all other inputs each cycle → y stays 1.
- Async reset mid-stream: assert rst between edges while y=1 → y=0 within the same cycle. Deassert → the next edge reloads the selected value.
- OUT_REG=0, WIDTH=4: a3=4'hA, sel=3 → y=4'hA with no clock edge. Change sel to 0 with a0=4'h5 → y=4'h5 immediately.
